// File: rtl/regwrite_arbiter.sv
// -----------------------------------------------------------------------------
// regwrite_arbiter
//
// Merges two writeback requesters (A = ALU, B = load unit) onto the single
// write port of RegMem. One request is accepted per cycle, ties are settled
// round-robin, and the accepted write is registered and shown to RegMem one
// cycle later. While that write is in flight, decode can pick its value up
// through the forwarding outputs before RegMem commits it.
//
// Ports:
//   i_clock, i_reset            clock and synchronous active-high reset
//   i_a_* / o_a_ready           port A request (valid/addr/val) and grant
//   i_b_* / o_b_ready           port B request (valid/addr/val) and grant
//   i_hold                      suppresses every grant this cycle
//   i_reg1_addr, i_reg2_addr    decode read addresses for the forwarding compare
//   o_regW_en/addr/val          registered write to RegMem
//   o_fwd1, o_fwd2, o_fwd_val   forwarding match flags and in-flight data
//   o_conflicts                 saturating count of unheld contention cycles
// -----------------------------------------------------------------------------
module regwrite_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter bit ZERO_DISCARD = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,

    input  logic              i_a_valid,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_val,
    output logic              o_a_ready,

    input  logic              i_b_valid,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_val,
    output logic              o_b_ready,

    input  logic              i_hold,

    input  logic [ADDR_W-1:0] i_reg1_addr,
    input  logic [ADDR_W-1:0] i_reg2_addr,

    output logic              o_regW_en,
    output logic [ADDR_W-1:0] o_regW_addr,
    output logic [DATA_W-1:0] o_regW_val,

    output logic              o_fwd1,
    output logic              o_fwd2,
    output logic [DATA_W-1:0] o_fwd_val,

    output logic [CNT_W-1:0]  o_conflicts
);

    // last_grant encoding: which port won the most recent grant.
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    // Registered state.
    logic              regw_en_q,   regw_en_d;
    logic [ADDR_W-1:0] regw_addr_q, regw_addr_d;
    logic [DATA_W-1:0] regw_val_q,  regw_val_d;
    grant_e            last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  conflicts_q, conflicts_d;

    // Combinational grants.
    logic grant_a;
    logic grant_b;
    logic contention;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_val;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        grant_a      = 1'b0;
        grant_b      = 1'b0;
        sel_addr     = i_a_addr;
        sel_val      = i_a_val;
        regw_en_d    = 1'b0;
        regw_addr_d  = regw_addr_q;
        regw_val_d   = regw_val_q;
        last_grant_d = last_grant_q;
        conflicts_d  = conflicts_q;

        // Both valid: A wins only when B had the previous grant.
        // Reset gates the grants too, so nothing is accepted during reset.
        contention = i_a_valid & i_b_valid & ~i_hold;
        if (!i_reset && !i_hold) begin
            grant_a = i_a_valid & (~i_b_valid | (last_grant_q == GRANT_B));
            grant_b = i_b_valid & (~i_a_valid | (last_grant_q == GRANT_A));
        end

        if (grant_b) begin
            sel_addr = i_b_addr;
            sel_val  = i_b_val;
        end

        // Stage register: load on a grant, otherwise drop enable and hold
        // address/data so the forwarding value stays stable.
        if (grant_a || grant_b) begin
            regw_addr_d  = sel_addr;
            regw_val_d   = sel_val;
            regw_en_d    = !(ZERO_DISCARD && (sel_addr == '0));
            last_grant_d = grant_b ? GRANT_B : GRANT_A;
        end

        // Saturating contention counter.
        if (contention && !(&conflicts_q)) begin
            conflicts_d = conflicts_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its _d value from before the edge, regardless of statement order.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            regw_en_q    <= 1'b0;
            regw_addr_q  <= '0;
            regw_val_q   <= '0;
            last_grant_q <= GRANT_B;
            conflicts_q  <= '0;
        end else begin
            regw_en_q    <= regw_en_d;
            regw_addr_q  <= regw_addr_d;
            regw_val_q   <= regw_val_d;
            last_grant_q <= last_grant_d;
            conflicts_q  <= conflicts_d;
        end
    end

    assign o_a_ready   = grant_a;
    assign o_b_ready   = grant_b;

    assign o_regW_en   = regw_en_q;
    assign o_regW_addr = regw_addr_q;
    assign o_regW_val  = regw_val_q;

    // A discarded address-0 write leaves regw_en_q low, so it never forwards.
    assign o_fwd1      = regw_en_q & (i_reg1_addr == regw_addr_q);
    assign o_fwd2      = regw_en_q & (i_reg2_addr == regw_addr_q);
    assign o_fwd_val   = regw_val_q;

    assign o_conflicts = conflicts_q;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regwrite_arbiter
//
// Directed bench for regwrite_arbiter with default parameters. A small RegMem
// model commits o_regW_* at each rising edge (writes are ignored while reset
// is asserted), so committed register contents can be checked as well.
// -----------------------------------------------------------------------------
module tb_regwrite_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              i_clock = 1'b0;
    logic              i_reset;
    logic              i_a_valid;
    logic [ADDR_W-1:0] i_a_addr;
    logic [DATA_W-1:0] i_a_val;
    logic              o_a_ready;
    logic              i_b_valid;
    logic [ADDR_W-1:0] i_b_addr;
    logic [DATA_W-1:0] i_b_val;
    logic              o_b_ready;
    logic              i_hold;
    logic [ADDR_W-1:0] i_reg1_addr;
    logic [ADDR_W-1:0] i_reg2_addr;
    logic              o_regW_en;
    logic [ADDR_W-1:0] o_regW_addr;
    logic [DATA_W-1:0] o_regW_val;
    logic              o_fwd1;
    logic              o_fwd2;
    logic [DATA_W-1:0] o_fwd_val;
    logic [CNT_W-1:0]  o_conflicts;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] regmem [32] = '{default: '0};

    regwrite_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .ZERO_DISCARD(1'b1),
        .CNT_W       (CNT_W)
    ) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_a_valid  (i_a_valid),
        .i_a_addr   (i_a_addr),
        .i_a_val    (i_a_val),
        .o_a_ready  (o_a_ready),
        .i_b_valid  (i_b_valid),
        .i_b_addr   (i_b_addr),
        .i_b_val    (i_b_val),
        .o_b_ready  (o_b_ready),
        .i_hold     (i_hold),
        .i_reg1_addr(i_reg1_addr),
        .i_reg2_addr(i_reg2_addr),
        .o_regW_en  (o_regW_en),
        .o_regW_addr(o_regW_addr),
        .o_regW_val (o_regW_val),
        .o_fwd1     (o_fwd1),
        .o_fwd2     (o_fwd2),
        .o_fwd_val  (o_fwd_val),
        .o_conflicts(o_conflicts)
    );

    always #5 i_clock = ~i_clock;

    // RegMem model: commits one write per edge, held off by reset.
    always @(posedge i_clock) begin
        if (!i_reset && o_regW_en) begin
            regmem[o_regW_addr] <= o_regW_val;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        i_a_valid = 1'b0; i_a_addr = '0; i_a_val = '0;
        i_b_valid = 1'b0; i_b_addr = '0; i_b_val = '0;
        i_hold    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
    endtask

    initial begin
        i_reset     = 1'b1;
        i_reg1_addr = '0;
        i_reg2_addr = '0;
        idle_inputs();

        // ---- Reset state; requests are refused while reset is high ----
        tick();
        i_a_valid = 1'b1; i_a_addr = 5'd3; i_a_val = 32'd4;
        i_b_valid = 1'b1; i_b_addr = 5'd6; i_b_val = 32'd7;
        settle();
        check("rst_a_ready", 64'(o_a_ready), 64'd0);
        check("rst_b_ready", 64'(o_b_ready), 64'd0);
        tick();
        check("rst_en",   64'(o_regW_en),   64'd0);
        check("rst_addr", 64'(o_regW_addr), 64'd0);
        check("rst_val",  64'(o_regW_val),  64'd0);
        check("rst_cnt",  64'(o_conflicts), 64'd0);
        idle_inputs();
        i_reset = 1'b0;

        // ---- A only: addr 3, val 4 ----
        i_a_valid = 1'b1; i_a_addr = 5'd3; i_a_val = 32'd4;
        settle();
        check("a_only_a_ready", 64'(o_a_ready), 64'd1);
        check("a_only_b_ready", 64'(o_b_ready), 64'd0);
        tick();
        idle_inputs();
        check("a_only_en",   64'(o_regW_en),   64'd1);
        check("a_only_addr", 64'(o_regW_addr), 64'd3);
        check("a_only_val",  64'(o_regW_val),  64'd4);
        tick();
        check("a_only_en_drop", 64'(o_regW_en), 64'd0);
        check("a_only_mem3",    64'(regmem[3]), 64'd4);

        // ---- Tie from reset: A (2,6) first, then B (5,9) ----
        do_reset();
        i_a_valid = 1'b1; i_a_addr = 5'd2; i_a_val = 32'd6;
        i_b_valid = 1'b1; i_b_addr = 5'd5; i_b_val = 32'd9;
        settle();
        check("tie_a_ready", 64'(o_a_ready), 64'd1);
        check("tie_b_wait",  64'(o_b_ready), 64'd0);
        tick();
        i_a_valid = 1'b0;
        check("tie_addr1", 64'(o_regW_addr), 64'd2);
        check("tie_val1",  64'(o_regW_val),  64'd6);
        settle();
        check("tie_b_ready", 64'(o_b_ready), 64'd1);
        tick();
        idle_inputs();
        check("tie_addr2", 64'(o_regW_addr), 64'd5);
        check("tie_val2",  64'(o_regW_val),  64'd9);
        check("tie_en2",   64'(o_regW_en),   64'd1);
        check("tie_cnt",   64'(o_conflicts), 64'd1);

        // ---- Sustained contention for 6 cycles, fresh payloads ----
        do_reset();
        for (int i = 0; i < 6; i++) begin
            i_a_valid = 1'b1; i_a_addr = 5'(10 + i); i_a_val = 32'(100 + i);
            i_b_valid = 1'b1; i_b_addr = 5'(20 + i); i_b_val = 32'(200 + i);
            settle();
            check("rr_a_ready", 64'(o_a_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            check("rr_b_ready", 64'(o_b_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
            check("rr_one_hot", 64'(o_a_ready & o_b_ready), 64'd0);
            tick();
            check("rr_addr", 64'(o_regW_addr), (i % 2 == 0) ? 64'(10 + i) : 64'(20 + i));
            check("rr_val",  64'(o_regW_val),  (i % 2 == 0) ? 64'(100 + i) : 64'(200 + i));
        end
        idle_inputs();
        check("rr_cnt", 64'(o_conflicts), 64'd6);

        // ---- Forwarding: A writes 7 <- 0xDEAD ----
        i_a_valid = 1'b1; i_a_addr = 5'd7; i_a_val = 32'hDEAD;
        tick();
        idle_inputs();
        i_reg1_addr = 5'd7; i_reg2_addr = 5'd8;
        settle();
        check("fwd1_hit",  64'(o_fwd1),    64'd1);
        check("fwd2_miss", 64'(o_fwd2),    64'd0);
        check("fwd_val",   64'(o_fwd_val), 64'hDEAD);

        // ---- B writes address 0: accepted, never issued or forwarded ----
        i_b_valid = 1'b1; i_b_addr = 5'd0; i_b_val = 32'h55;
        settle();
        check("zero_b_ready", 64'(o_b_ready), 64'd1);
        tick();
        idle_inputs();
        i_reg1_addr = 5'd0;
        settle();
        check("zero_en",   64'(o_regW_en),   64'd0);
        check("zero_fwd1", 64'(o_fwd1),      64'd0);
        check("zero_addr", 64'(o_regW_addr), 64'd0);

        // ---- Hold with both ports valid: no grant, no count ----
        i_a_valid = 1'b1; i_a_addr = 5'd1; i_a_val = 32'd11;
        i_b_valid = 1'b1; i_b_addr = 5'd2; i_b_val = 32'd22;
        i_hold    = 1'b1;
        settle();
        check("hold_a_ready", 64'(o_a_ready), 64'd0);
        check("hold_b_ready", 64'(o_b_ready), 64'd0);
        tick();
        idle_inputs();
        check("hold_en",  64'(o_regW_en),   64'd0);
        check("hold_cnt", 64'(o_conflicts), 64'd6);

        // ---- Same address from both ports: last granted value persists ----
        do_reset();
        i_a_valid = 1'b1; i_a_addr = 5'd9; i_a_val = 32'd1;
        i_b_valid = 1'b1; i_b_addr = 5'd9; i_b_val = 32'd2;
        tick();
        i_a_valid = 1'b0;
        tick();
        idle_inputs();
        tick();
        check("same_addr_mem9", 64'(regmem[9]), 64'd2);

        // ---- Reset drops an in-flight write: A (4,1) then reset ----
        i_a_valid = 1'b1; i_a_addr = 5'd4; i_a_val = 32'd1;
        settle();
        check("inflight_a_ready", 64'(o_a_ready), 64'd1);
        tick();
        idle_inputs();
        check("inflight_en", 64'(o_regW_en), 64'd1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("inflight_drop_en", 64'(o_regW_en), 64'd0);
        tick();
        check("inflight_mem4", 64'(regmem[4]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
